// File: rtl/data_bridge.sv
// Single-outstanding bridge from a stalling CPU data port to AXI read/write channels.
// The request is captured on leaving IDLE; AXI fields are derived from the captured copy.
module data_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [2:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_stall,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t      state;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        aw_done;
  logic        w_done;
  logic        aw_fin;
  logic        w_fin;
  logic        resp_unused;

  // Sizes 3..7 collapse onto word.
  function automatic logic [1:0] size_code(input logic [2:0] size);
    if (size == 3'd0)      return 2'd0;
    else if (size == 3'd1) return 2'd1;
    else                   return 2'd2;
  endfunction

  function automatic logic [3:0] strobe_for(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      2'd0:    return 4'b0001 << lsb;
      2'd1:    return lsb[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_replicate(input logic [1:0] size, input logic [31:0] data);
    case (size)
      2'd0:    return {4{data[7:0]}};
      2'd1:    return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  // Response codes carry no meaning for the CPU side; errors complete like OKAY.
  assign resp_unused = ^{rresp, bresp};

  assign d_stall = d_req & (state != DONE);
  assign araddr  = req_addr;
  assign awaddr  = req_addr;
  assign arsize  = {1'b0, req_size};
  assign awsize  = {1'b0, req_size};
  assign wstrb   = strobe_for(req_size, req_addr[1:0]);
  assign wdata   = lane_replicate(req_size, req_wdata);

  // Address and data channels may finish in either order or together.
  assign aw_fin = aw_done | (awvalid & awready);
  assign w_fin  = w_done  | (wvalid  & wready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      d_rdata   <= 32'd0;
      req_size  <= 2'd0;
      req_addr  <= 32'd0;
      req_wdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (d_req) begin
            req_size  <= size_code(d_size);
            req_addr  <= d_addr;
            req_wdata <= d_wdata;
            if (d_wr) begin
              state   <= WR_REQ;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              aw_done <= 1'b0;
              w_done  <= 1'b0;
            end else begin
              state   <= RD_ADDR;
              arvalid <= 1'b1;
            end
          end
        end
        RD_ADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (rvalid) begin
            d_rdata <= rdata;
            rready  <= 1'b0;
            state   <= DONE;
          end
        end
        WR_REQ: begin
          if (awvalid && awready) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (wvalid && wready) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            bready <= 1'b1;
            state  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bvalid) begin
            bready <= 1'b0;
            state  <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_bridge.sv
// Directed bench for data_bridge: table of load/store transactions against a
// scripted AXI responder, plus reset and mid-transaction reset sequences.
module tb_data_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        d_req, d_wr;
  logic [2:0]  d_size;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        d_stall;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [2:0]  arsize, awsize;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  rresp, bresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] last_load = 32'd0;

  always #5 clk = ~clk;

  data_bridge dut (
    .clk(clk), .rst(rst),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_stall(d_stall),
    .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct {
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [31:0] rdat;
    logic [1:0]  resp;
    int          rv_at;
    int          aw_at;
    int          w_at;
    int          b_at;
    logic [2:0]  exp_axsize;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    int          exp_stall;
    int          exp_aw_cyc;
    int          exp_w_cyc;
  } vec_t;

  vec_t vecs[9];
  vec_t recov;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Cycle k=0 is the IDLE cycle in which the request is presented.
  task automatic run_txn(input vec_t v);
    int stall = 0;
    int aw_cyc = 0;
    int w_cyc = 0;
    bit ar_seen = 0;
    bit aw_seen = 0;
    bit w_seen = 0;
    bit done = 0;
    @(negedge clk);
    d_req = 1'b1; d_wr = v.wr; d_size = v.size; d_addr = v.addr; d_wdata = v.wdat;
    rdata = v.rdat; rresp = v.resp; bresp = v.resp;
    for (int k = 0; k < 40 && !done; k++) begin
      if (k > 0) @(negedge clk);
      arready = 1'b1;
      rvalid  = (k >= v.rv_at);
      awready = (k >= v.aw_at);
      wready  = (k >= v.w_at);
      bvalid  = (k >= v.b_at);
      #1;
      if (k == 0)
        check("idle_channels", {27'd0, arvalid, rready, awvalid, wvalid, bready}, 32'd0);
      if (!d_stall) begin
        done = 1;
      end else begin
        stall++;
        if (arvalid && !ar_seen) begin
          ar_seen = 1;
          check("araddr", araddr, v.addr);
          check("arsize", {29'd0, arsize}, {29'd0, v.exp_axsize});
        end
        if (awvalid && !aw_seen) begin
          aw_seen = 1;
          check("awaddr", awaddr, v.addr);
          check("awsize", {29'd0, awsize}, {29'd0, v.exp_axsize});
        end
        if (wvalid && !w_seen) begin
          w_seen = 1;
          check("wdata", wdata, v.exp_wdata);
          check("wstrb", {28'd0, wstrb}, {28'd0, v.exp_strb});
        end
        if (awvalid) aw_cyc++;
        if (wvalid) w_cyc++;
      end
    end
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL timeout: d_stall still high after 40 cycles, addr %h", v.addr);
    end
    if (!v.wr) last_load = v.rdat;
    check("stall_cycles", stall, v.exp_stall);
    check("done_channels", {27'd0, arvalid, rready, awvalid, wvalid, bready}, 32'd0);
    check("d_rdata", d_rdata, last_load);
    check("channels_used", {29'd0, ar_seen, aw_seen, w_seen}, v.wr ? 32'd3 : 32'd4);
    if (v.wr) begin
      check("aw_valid_cycles", aw_cyc, v.exp_aw_cyc);
      check("w_valid_cycles", w_cyc, v.exp_w_cyc);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //        wr  sz    addr           wdata          rdata          resp   rv aw w  b  axsz strb    exp_wdata      stl awc wc
    vecs[0] = '{1'b0, 3'd2, 32'h1000_0004, 32'h0,         32'hDEAD_BEEF, 2'b00, 2, 0, 0, 0, 3'd2, 4'h0, 32'h0,         3, 0, 0};
    vecs[1] = '{1'b0, 3'd0, 32'h2000_0001, 32'h0,         32'h1122_3344, 2'b10, 4, 0, 0, 0, 3'd0, 4'h0, 32'h0,         5, 0, 0};
    vecs[2] = '{1'b0, 3'd1, 32'h3000_0002, 32'h0,         32'hCAFE_F00D, 2'b00, 0, 0, 0, 0, 3'd1, 4'h0, 32'h0,         3, 0, 0};
    vecs[3] = '{1'b1, 3'd0, 32'h4000_0003, 32'hFFFF_FF5A, 32'h0,         2'b00, 0, 0, 0, 4, 3'd0, 4'h8, 32'h5A5A_5A5A, 5, 1, 1};
    vecs[4] = '{1'b1, 3'd1, 32'h5000_0002, 32'hABCD_1234, 32'h0,         2'b00, 0, 1, 2, 0, 3'd1, 4'hC, 32'h1234_1234, 4, 1, 2};
    vecs[5] = '{1'b1, 3'd1, 32'h5000_0001, 32'h0000_BEEF, 32'h0,         2'b00, 0, 3, 0, 0, 3'd1, 4'h3, 32'hBEEF_BEEF, 5, 3, 1};
    vecs[6] = '{1'b1, 3'd3, 32'h6000_0003, 32'h0123_4567, 32'h0,         2'b11, 0, 0, 0, 0, 3'd2, 4'hF, 32'h0123_4567, 3, 1, 1};
    vecs[7] = '{1'b1, 3'd0, 32'h6000_0001, 32'h0000_00A5, 32'h0,         2'b00, 0, 0, 0, 0, 3'd0, 4'h2, 32'hA5A5_A5A5, 3, 1, 1};
    vecs[8] = '{1'b0, 3'd7, 32'h7000_0008, 32'h0,         32'h0BAD_C0DE, 2'b00, 0, 0, 0, 0, 3'd2, 4'h0, 32'h0,         3, 0, 0};
    recov   = '{1'b0, 3'd2, 32'h9000_000C, 32'h0,         32'h600D_F00D, 2'b00, 1, 0, 0, 0, 3'd2, 4'h0, 32'h0,         3, 0, 0};

    rst = 1'b1; d_req = 1'b0; d_wr = 1'b0; d_size = 3'd0; d_addr = 32'd0; d_wdata = 32'd0;
    arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rresp = 2'b00;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_channels", {27'd0, arvalid, rready, awvalid, wvalid, bready}, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_d_stall", {31'd0, d_stall}, 32'd0);
    check("rst_araddr", araddr, 32'd0);

    // Request held high across every transaction: back-to-back from DONE into IDLE.
    for (int i = 0; i < 9; i++) run_txn(vecs[i]);

    // Reset while waiting in RD_DATA abandons the load.
    @(negedge clk);
    d_req = 1'b1; d_wr = 1'b0; d_size = 3'd2; d_addr = 32'h8000_0010;
    arready = 1'b1; rvalid = 1'b0; rdata = 32'h5555_AAAA;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("mid_rready", {31'd0, rready}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; d_req = 1'b0;
    #1;
    check("midrst_channels", {27'd0, arvalid, rready, awvalid, wvalid, bready}, 32'd0);
    check("midrst_d_rdata", d_rdata, 32'd0);
    check("midrst_d_stall", {31'd0, d_stall}, 32'd0);
    d_req = 1'b1;
    #1;
    check("midrst_stall_req", {31'd0, d_stall}, 32'd1);
    d_req = 1'b0;
    last_load = 32'd0;
    run_txn(recov);

    @(negedge clk);
    d_req = 1'b0;
    #1;
    check("final_stall_idle", {31'd0, d_stall}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/data_bridge.md
DATA_BRIDGE -- requirements
Module: data_bridge

Interface
REQ-001 SHALL provide port: clk  input  1  system clock; all logic on rising edge.
REQ-002 SHALL provide port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL provide CPU-side inputs: d_req 1 (access request), d_wr 1 (1=store, 0=load), d_size 3 (0=byte, 1=half, 2=word; 3..7 treated as word), d_addr 32, d_wdata 32 (store data in low bits).
REQ-004 SHALL provide CPU-side outputs: d_rdata 32 (raw aligned word from memory), d_stall 1 (high while request incomplete).
REQ-005 SHALL provide AXI read address/data ports: araddr 32, arsize 3, arvalid out; arready in; rdata 32, rresp 2, rvalid in; rready out.
REQ-006 SHALL provide AXI write ports: awaddr 32, awsize 3, awvalid out; awready in; wdata 32, wstrb 4, wvalid out; wready in; bresp 2, bvalid in; bready out.

Function
REQ-007 SHALL implement FSM states IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
REQ-008 IDLE: d_req&!d_wr -> RD_ADDR; d_req&d_wr -> WR_REQ; else stay.
REQ-009 RD_ADDR: arvalid=1; arvalid&arready -> RD_DATA.
REQ-010 RD_DATA: rready=1; on rvalid latch rdata into d_rdata register, -> DONE.
REQ-011 WR_REQ: awvalid and wvalid asserted together on entry; each deasserted independently after its own handshake (aw_done, w_done flags); when both done (same or different cycles) -> WR_RESP.
REQ-012 WR_RESP: bready=1; on bvalid -> DONE.
REQ-013 DONE: lasts exactly one cycle, d_stall=0, d_rdata valid for loads; next state IDLE unconditionally.
REQ-014 d_stall SHALL be combinational: d_req & (state != DONE); d_stall=0 whenever d_req=0.
REQ-015 CPU SHALL hold d_req, d_wr, d_size, d_addr, d_wdata stable while d_stall=1; bridge SHALL latch them on the IDLE->busy transition and drive AXI from latched copies.
REQ-016 araddr/awaddr SHALL equal latched d_addr unmodified; arsize/awsize = 0/1/2 for byte/half/word.
REQ-017 wstrb: byte -> 4'b0001<<addr[1:0]; half -> addr[1]?4'b1100:4'b0011; word -> 4'b1111.
REQ-018 wdata: byte -> {4{d_wdata[7:0]}}; half -> {2{d_wdata[15:0]}}; word -> d_wdata.
REQ-019 Misaligned half/word addresses SHALL NOT be checked; half uses addr[1] only, word ignores addr[1:0] for strobes.
REQ-020 rresp/bresp non-zero SHALL be ignored; transaction completes normally.
REQ-021 At most one outstanding AXI transaction; a new request accepted only from IDLE, earliest the cycle after DONE.
REQ-022 A ready already high when valid rises SHALL complete that channel in the same cycle (min load latency: IDLE, RD_ADDR, RD_DATA, DONE = 3 cycles of stall).
REQ-023 d_rdata SHALL hold last loaded value until next load completes; stores SHALL NOT alter it.

Reset
REQ-024 On rst=1 at a clock edge: state=IDLE, arvalid=awvalid=wvalid=rready=bready=0, aw_done=w_done=0, d_rdata=0, latched request regs=0.
REQ-025 rst mid-transaction SHALL abandon it without completion; d_stall follows REQ-014 from IDLE on the next cycle.
REQ-026 Reset-abandon of an in-flight AXI transaction is permitted only under system-wide reset.

Verification
REQ-027 Load word addr 0x1000_0004, arready=1, rvalid=1 with rdata 0xDEAD_BEEF one cycle later -> araddr=0x1000_0004, arsize=2, d_stall high 3 cycles, DONE cycle d_rdata=0xDEAD_BEEF.
REQ-028 Store byte 0x5A to addr 0x...0003 -> wdata=0x5A5A_5A5A, wstrb=4'b1000, awsize=0; bvalid after 2 cycles -> DONE one cycle, then IDLE.
REQ-029 Store half 0x1234 to addr 0x...0002, awready one cycle before wready -> awvalid drops after its handshake, wvalid held until wready, wstrb=4'b1100, wdata=0x1234_1234.
REQ-030 Back-to-back load then store with d_req held -> no AXI activity in DONE cycle; second request starts from IDLE the following cycle.
REQ-031 rst asserted while in RD_DATA -> next cycle state IDLE, all valids/readys 0, d_rdata=0.
REQ-032 rresp=2'b10 on load -> completes normally, d_rdata equals returned rdata.
